// File: rtl/ps2_kbd_rx_if.sv
// rtl/ps2_kbd_rx_if.sv - byte-level keyboard code interface between ps2_kbd_rx and its consumer
//
// Signals:
//   code_o   [7:0]  last correctly received scan-code byte
//   strobe_o        one-cycle pulse, code_o newly valid
//   err_o           one-cycle pulse on framing, parity or timeout error
// Modports:
//   master  driven by the receiver
//   slave   sampled by the consumer (no back-pressure)

interface ps2_kbd_rx_if;
    logic [7:0] code_o;
    logic       strobe_o;
    logic       err_o;

    modport master (output code_o, output strobe_o, output err_o);
    modport slave  (input  code_o, input  strobe_o, input  err_o);
endinterface

// File: rtl/ps2_kbd_rx.sv
// rtl/ps2_kbd_rx.sv - PS/2 device-to-host frame receiver with deglitching and error detection
//
// Ports:
//   clk         system clock, all logic on its rising edge
//   reset_i     synchronous active-low reset
//   ps2_clk_i   raw PS/2 clock pin (asynchronous)
//   ps2_data_i  raw PS/2 data pin (asynchronous)
//   kbd         ps2_kbd_rx_if.master: code_o / strobe_o / err_o
// Parameters:
//   FREQ_HZ     system clock frequency in Hz
//   FILTER_LEN  consecutive equal samples needed to move the filtered clock (2..16)
//   TIMEOUT_US  maximum gap between falling PS/2 clock edges inside a frame
// Build option:
//   PS2_KBD_RX_TIMEOUT_EN  when defined, builds the inter-edge timeout counter and timeout error

module ps2_kbd_rx #(
    parameter int unsigned FREQ_HZ    = 25_000_000,
    parameter int unsigned FILTER_LEN = 4,
    parameter int unsigned TIMEOUT_US = 200
) (
    input  logic         clk,
    input  logic         reset_i,
    input  logic         ps2_clk_i,
    input  logic         ps2_data_i,
    ps2_kbd_rx_if.master kbd
);

    localparam int unsigned TIMEOUT_CYCLES = FREQ_HZ / 1_000_000 * TIMEOUT_US;

    generate
        if (FILTER_LEN < 2 || FILTER_LEN > 16 || TIMEOUT_CYCLES == 0) begin : g_bad_param
            $error("ps2_kbd_rx: FILTER_LEN must be 2..16 and the timeout must be at least one cycle");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Input conditioning. Everything resets to the idle (high) line level
    // so that leaving reset never looks like a falling edge.
    // ------------------------------------------------------------------
    logic [1:0]            clk_sync;
    logic [1:0]            data_sync;
    logic [FILTER_LEN-1:0] clk_hist;
    logic [FILTER_LEN-1:0] data_hist;
    logic                  fclk;
    logic                  fdata;
    logic                  all_low;
    logic                  all_high;
    logic                  fall;

    assign all_low  = (clk_hist == '0);
    assign all_high = &clk_hist;
    // Data runs through the same number of stages as the clock, so the
    // oldest data tap lines up with the clock sample that completes a fall.
    assign fdata    = data_hist[FILTER_LEN-1];
    // Decoded from the next-state condition rather than a registered copy,
    // so the FSM acts on the same edge that moves fclk low.
    assign fall     = fclk & all_low;

    always_ff @(posedge clk) begin
        if (!reset_i) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_hist  <= '1;
            data_hist <= '1;
            fclk      <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_i};
            data_sync <= {data_sync[0], ps2_data_i};
            clk_hist  <= {clk_hist[FILTER_LEN-2:0], clk_sync[1]};
            data_hist <= {data_hist[FILTER_LEN-2:0], data_sync[1]};
            if (all_low) begin
                fclk <= 1'b0;
            end else if (all_high) begin
                fclk <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM with registered outputs.
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t     state;
    logic [2:0] bitcnt;
    logic [7:0] sr;
    logic       par_ok;

`ifdef PS2_KBD_RX_TIMEOUT_EN
    localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT_CYCLES);
    logic [TCNT_W-1:0] tcnt;
`endif

    always_ff @(posedge clk) begin
        if (!reset_i) begin
            state        <= IDLE;
            bitcnt       <= 3'd0;
            sr           <= 8'h00;
            par_ok       <= 1'b0;
            kbd.code_o   <= 8'h00;
            kbd.strobe_o <= 1'b0;
            kbd.err_o    <= 1'b0;
`ifdef PS2_KBD_RX_TIMEOUT_EN
            tcnt         <= '0;
`endif
        end else begin
            kbd.strobe_o <= 1'b0;
            kbd.err_o    <= 1'b0;

`ifdef PS2_KBD_RX_TIMEOUT_EN
            if (fall || state == IDLE) begin
                tcnt <= '0;
            end else if (tcnt != TCNT_MAX) begin
                tcnt <= tcnt + 1'b1;
            end
`endif

            // A fall coinciding with expiry is processed as an edge; the
            // timeout branch below is only reached without a fall.
            if (fall) begin
                unique case (state)
                    IDLE: begin
                        // A high data line on a fall is not a start bit.
                        if (!fdata) begin
                            bitcnt <= 3'd0;
                            sr     <= 8'h00;
                            state  <= DATA;
                        end
                    end
                    DATA: begin
                        sr     <= {fdata, sr[7:1]};
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_ok <= ^{sr, fdata};
                        state  <= STOP;
                    end
                    STOP: begin
                        if (fdata && par_ok) begin
                            kbd.code_o   <= sr;
                            kbd.strobe_o <= 1'b1;
                        end else begin
                            kbd.err_o <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
`ifdef PS2_KBD_RX_TIMEOUT_EN
            else if (state != IDLE && tcnt == TCNT_MAX) begin
                kbd.err_o <= 1'b1;
                state     <= IDLE;
            end
`endif
        end
    end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb/tb_ps2_kbd_rx.sv - scoreboard testbench for ps2_kbd_rx

module tb_ps2_kbd_rx;

    localparam int FREQ = 2_000_000;
    localparam int FL   = 4;
    localparam int TUS  = 200;
    localparam int TCYC = FREQ / 1_000_000 * TUS;
    localparam int LAT  = 3 + FL;

    logic clk      = 1'b0;
    logic reset_i  = 1'b0;
    logic ps2_clk  = 1'b1;
    logic ps2_data = 1'b1;

    ps2_kbd_rx_if kbd ();

    ps2_kbd_rx #(
        .FREQ_HZ    (FREQ),
        .FILTER_LEN (FL),
        .TIMEOUT_US (TUS)
    ) u_dut (
        .clk        (clk),
        .reset_i    (reset_i),
        .ps2_clk_i  (ps2_clk),
        .ps2_data_i (ps2_data),
        .kbd        (kbd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] code;
        int         lo;
        int         hi;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    // Reference model: a frame is a start bit followed by ten further
    // sampled bits (8 data LSB-first, parity, stop).
    bit         m_in_frame = 0;
    bit         m_bits[$];
    logic [7:0] m_last_code = 8'h00;
    int         m_last_fall = 0;

    function automatic void model_fall(bit d, int c);
        logic [7:0] v;
        bit         ok;
        if (!m_in_frame) begin
            if (!d) begin
                m_in_frame = 1;
                m_bits.delete();
            end
        end else begin
            m_bits.push_back(d);
            if (m_bits.size() == 10) begin
                v = 8'h00;
                for (int i = 0; i < 8; i++) v[i] = m_bits[i];
                ok = ((($countones(v) + int'(m_bits[8])) % 2) == 1) && m_bits[9];
                if (ok) begin
                    m_last_code = v;
                    exp_q.push_back('{1'b0, v, c + LAT, c + LAT});
                end else begin
                    exp_q.push_back('{1'b1, m_last_code, c + LAT, c + LAT});
                end
                m_in_frame = 0;
            end
        end
        m_last_fall = c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One PS/2 bit: data set during the high phase, then a low pulse.
    task automatic ps2_bit(input bit d, input int lo, input int hi);
        @(negedge clk);
        ps2_data = d;
        repeat (hi) @(negedge clk);
        ps2_clk = 1'b0;
        model_fall(d, cyc);
        repeat (lo) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] v, input bit par_flip, input bit stop_v,
                              input int lo, input int hi);
        bit p;
        p = ~(^v) ^ par_flip;
        ps2_bit(1'b0, lo, hi);
        for (int i = 0; i < 8; i++) ps2_bit(v[i], lo, hi);
        ps2_bit(p, lo, hi);
        ps2_bit(stop_v, lo, hi);
        @(negedge clk);
        ps2_data = 1'b1;
    endtask

    task automatic idle(input int n);
`ifdef PS2_KBD_RX_TIMEOUT_EN
        if (m_in_frame && (cyc + n - m_last_fall) > TCYC + 20) begin
            exp_q.push_back('{1'b1, m_last_code, m_last_fall + TCYC, m_last_fall + TCYC + LAT + 1});
            m_in_frame = 0;
        end
`endif
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (10) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset_i = 1'b0;
        @(negedge clk);
        m_in_frame  = 0;
        m_last_code = 8'h00;
        chk("reset_code", kbd.code_o, 8'h00);
        chk("reset_strobe", kbd.strobe_o, 1'b0);
        chk("reset_err", kbd.err_o, 1'b0);
        reset_i = 1'b1;
    endtask

    // Monitor: every output event is checked against the scoreboard head.
    always @(negedge clk) begin
        if (reset_i && (kbd.strobe_o || kbd.err_o)) begin
            if (kbd.strobe_o && kbd.err_o) begin
                n_cmp++;
                n_bad++;
                $display("FAIL both_pulses: strobe and err high together at cycle %0d", cyc);
            end else if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_event: err=%0b code=%02h at cycle %0d, none expected",
                         kbd.err_o, kbd.code_o, cyc);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                n_cmp++;
                if (kbd.err_o !== e.is_err || kbd.code_o !== e.code || cyc < e.lo || cyc > e.hi) begin
                    n_bad++;
                    $display("FAIL event: got err=%0b code=%02h cycle=%0d, expected err=%0b code=%02h cycle %0d..%0d",
                             kbd.err_o, kbd.code_o, cyc, e.is_err, e.code, e.lo, e.hi);
                end
            end
        end
    end

    initial begin
        logic [7:0] v;
        int lo, hi;

        reset_i = 1'b0;
        repeat (5) @(negedge clk);
        chk("init_code", kbd.code_o, 8'h00);
        chk("init_strobe", kbd.strobe_o, 1'b0);
        chk("init_err", kbd.err_o, 1'b0);
        reset_i = 1'b1;
        idle(20);

        // Single good frame, then back-to-back frames.
        send_frame(8'h1C, 0, 1, 80, 80);
        idle(100);
        send_frame(8'hF0, 0, 1, 80, 80);
        send_frame(8'h1C, 0, 1, 80, 80);
        idle(100);

        // Parity error, then stop-bit error; code_o must hold.
        send_frame(8'h1C, 1, 1, 80, 80);
        idle(50);
        send_frame(8'h1C, 0, 0, 80, 80);
        idle(50);

        // Stalled frame after four data bits, then a good frame.
        v = 8'($urandom_range(0, 255));
        ps2_bit(1'b0, 80, 80);
        for (int i = 0; i < 4; i++) ps2_bit(v[i], 80, 80);
        idle(1000);
        send_frame(8'h5A, 0, 1, 80, 80);
        drain();
        pulse_reset();
        idle(50);

        // Short idle glitch and an edge with data high are both ignored.
        @(negedge clk);
        ps2_clk = 1'b0;
        repeat (2) @(negedge clk);
        ps2_clk = 1'b1;
        idle(20);
        ps2_bit(1'b1, 80, 80);
        idle(50);
        send_frame(8'h1C, 0, 1, 80, 80);
        idle(50);

        // Reset mid-frame, after the fifth data bit.
        ps2_bit(1'b0, 80, 80);
        for (int i = 0; i < 5; i++) ps2_bit(1'($urandom_range(0, 1)), 80, 80);
        idle(20);
        drain();
        pulse_reset();
        idle(50);
        send_frame(8'h1C, 0, 1, 80, 80);
        idle(50);

        // Randomized frames with varied timing and injected errors.
        for (int n = 0; n < 25; n++) begin
            v  = 8'($urandom_range(0, 255));
            lo = int'($urandom_range(30, 60));
            hi = int'($urandom_range(30, 60));
`ifdef PS2_KBD_RX_TIMEOUT_EN
            if ($urandom_range(0, 9) == 0) begin
                ps2_bit(1'b0, lo, hi);
                for (int i = 0; i < int'($urandom_range(0, 9)); i++) ps2_bit(1'($urandom_range(0, 1)), lo, hi);
                idle(TCYC + 100);
            end
`endif
            send_frame(v, $urandom_range(0, 5) == 0, $urandom_range(0, 7) != 0, lo, hi);
            idle(int'($urandom_range(0, 300)));
        end

        drain();
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
